riscv_front_stages: RTL and testbench
=====================================

# riscv_front_stages

Front three stages (fetch, decode/register-file, execute) of the veriRISCV 5-stage in-order RV32I pipeline. Fetches one word per cycle from a synchronous instruction RAM, decodes integer ALU instructions, reads a 32x32 register file written back from the WB stage, and executes the ALU operation with full forwarding. Results leave through the EX/MEM pipeline register to the external MEM and WB stages.

## Interface
- INSTR_RAM_AW, 16: instruction RAM word-address width
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_ram_rd  out  1  RAM read enable; 0 in reset, 1 otherwise
- instr_ram_addr  out  INSTR_RAM_AW  word address, equal to pc[INSTR_RAM_AW+1:2]
- instr_ram_din  in  32  read data, valid one cycle after the address
- wb_reg_wen  in  1  register-file write enable from WB
- wb_reg_waddr  in  5  register-file write address
- wb_reg_wdata  in  32  register-file write data; also the WB forwarding source
- ex2mem_reg_wen  out  1  instruction in MEM writes rd
- ex2mem_reg_waddr  out  5  rd of instruction in MEM
- ex2mem_alu_out  out  32  ALU result; also the MEM forwarding source
- ex2mem_ill_instr  out  1  instruction in MEM is illegal

## Operation
- IF:
  - pc register resets to 0 and increments by 4 every cycle. No branches, no stalls.
  - if_valid register resets to 0 and becomes 1 on the first edge after reset release.
  - if2id_pc is a registered copy of pc.
  - The ID instruction is instr_ram_din.
- ID:
  - Register file is 32x32 and x0 reads 0.
  - A write with wb_reg_wen=1 and waddr≠0 is visible to a same-cycle read (write-through bypass).
  - Legal instructions:
    - OP (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
    - OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
    - Illegal funct7 for OP or for shift-immediates, and every other opcode, is illegal.
  - Illegal instruction: ill_instr=1 and reg_wen=0.
  - reg_wen=1 only for a legal, valid instruction with rd≠0.
  - Immediate is I-type imm[11:0], sign-extended to 32 in EX; sel_imm=1 for OP-IMM.
  - Forward flags are computed in ID and registered into ID/EX; never set when rs=0.
    - rsN_forward_from_mem = (rsN == rd of instruction now in EX) and its reg_wen. Highest priority.
    - rsN_forward_from_wb = (rsN == ex2mem_reg_waddr) and ex2mem_reg_wen.
- EX:
  - Operand mux order per source: forward_from_mem → ex2mem_alu_out; else forward_from_wb → wb_reg_wdata; else the registered RF data.
  - Operand B is the sign-extended immediate when sel_imm=1.
  - ALU rules:
    - Arithmetic is mod 2^32.
    - Shift amount is B[4:0].
    - SLT is signed; SLTU and SLTIU compare unsigned after sign extension.
    - SRA/SRAI are arithmetic shifts.
  - Registers ex2mem_* every cycle.
- Bubble (if_valid=0): reg_wen=0, ill_instr=0, waddr=0, alu_out=0.
- External MEM stage is exactly one register stage, so ex2mem values at cycle t appear on wb_reg_* at cycle t+1.

## Timing
- Reset values: pc, if2id_pc, if_valid and all ID/EX and ex2mem registers are 0; instr_ram_addr=0; instr_ram_rd=0.
- Reset asserted mid-operation clears all of these immediately; in-flight instructions are dropped.
- Cycle 0 is the first cycle after reset release. Instruction at word n:
  - address driven in cycle n;
  - decoded in ID in cycle n+1;
  - executed in EX in cycle n+2;
  - visible on ex2mem_* in cycle n+3.
- Dependency distances (consumer issued k words after producer):
  - k=1 uses MEM forwarding.
  - k=2 uses WB forwarding.
  - k=3 uses the RF write-through bypass.
  - k≥4 reads the RF normally.
  - No stalls are ever required.
- instr_ram_addr wraps modulo 2^INSTR_RAM_AW; pc wraps modulo 2^32.

## Test plan
- Reset, then run 3 cycles → addr 0,1,2; first ex2mem_reg_wen=1 in cycle 3; outputs all 0 during reset.
- ADDI x1,x0,5; ADDI x2,x1,3; ADD x3,x1,x2 back-to-back → alu_out 5, 8, 13 on consecutive cycles, with MEM and WB forwarding exercised.
- ADDI x1,x0,-1, then three NOPs, then SRAI x4,x1,4 / SRLI x5,x1,28 → 0xFFFFFFFF, 0x0000000F (RF read path).
- SLT x6,x1,x0 and SLTU x7,x1,x0 with x1=-1 → 1 and 0.
- Word 0x0000006F (JAL) → ex2mem_ill_instr=1, reg_wen=0; word 0x40000033 → SUB x0 with reg_wen=0, ill=0.
- ADDI x0,x0,7 followed by ADDI x8,x0,1 → x0 never forwarded, result 1.

Source files
------------

// File: rtl/riscv_front_stages_if.sv
// rtl/riscv_front_stages_if.sv - bus bundle between the front pipeline stages and their environment
//
// Purpose: groups the instruction RAM port, the WB register-file write port and
// the EX/MEM pipeline outputs of riscv_front_stages.
// Signals:
//   instr_ram_rd / instr_ram_addr : RAM read enable and word address (core -> RAM)
//   instr_ram_din                 : RAM read data, one cycle after the address (RAM -> core)
//   wb_reg_wen/waddr/wdata        : register-file write from the WB stage (env -> core)
//   ex2mem_reg_wen/waddr          : destination of the instruction now in MEM (core -> env)
//   ex2mem_alu_out                : ALU result of the instruction now in MEM (core -> env)
//   ex2mem_ill_instr              : instruction now in MEM is illegal (core -> env)
// Modports: master = the core, slave = RAM / MEM / WB environment.
interface riscv_front_stages_if #(
  parameter int INSTR_RAM_AW = 16
);
  logic                    instr_ram_rd;
  logic [INSTR_RAM_AW-1:0] instr_ram_addr;
  logic [31:0]             instr_ram_din;
  logic                    wb_reg_wen;
  logic [4:0]              wb_reg_waddr;
  logic [31:0]             wb_reg_wdata;
  logic                    ex2mem_reg_wen;
  logic [4:0]              ex2mem_reg_waddr;
  logic [31:0]             ex2mem_alu_out;
  logic                    ex2mem_ill_instr;

  modport master (
    output instr_ram_rd, instr_ram_addr,
    output ex2mem_reg_wen, ex2mem_reg_waddr, ex2mem_alu_out, ex2mem_ill_instr,
    input  instr_ram_din, wb_reg_wen, wb_reg_waddr, wb_reg_wdata
  );

  modport slave (
    input  instr_ram_rd, instr_ram_addr,
    input  ex2mem_reg_wen, ex2mem_reg_waddr, ex2mem_alu_out, ex2mem_ill_instr,
    output instr_ram_din, wb_reg_wen, wb_reg_waddr, wb_reg_wdata
  );
endinterface

// File: rtl/riscv_front_stages.sv
// rtl/riscv_front_stages.sv - IF, ID/RF and EX stages of an in-order RV32I integer pipeline
//
// Purpose: fetches one word per cycle from a synchronous instruction RAM,
// decodes OP / OP-IMM ALU instructions, reads a 32x32 register file written
// back by WB, and executes with full MEM/WB forwarding into the EX/MEM register.
// Ports:
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : riscv_front_stages_if.master (instruction RAM, WB write port, EX/MEM outputs)
module riscv_front_stages #(
  parameter int INSTR_RAM_AW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_front_stages_if.master bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [2:0] F3_ADD     = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SR      = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;

  typedef struct packed {
    logic        valid;
    logic        reg_wen;
    logic        ill_instr;
    logic [4:0]  waddr;
    logic [2:0]  funct3;
    logic        alt;          // SUB / SRA / SRAI select
    logic        sel_imm;
    logic [11:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_fwd_mem;
    logic        rs1_fwd_wb;
    logic        rs2_fwd_mem;
    logic        rs2_fwd_wb;
  } id_ex_t;

  // ---------------------------------------------------------------- state
  logic [31:0] pc_q, pc_d;
  logic [31:0] if2id_pc_q, if2id_pc_d;
  logic        if_valid_q, if_valid_d;
  id_ex_t      id_ex_q, id_ex_d;
  logic        ex2mem_reg_wen_q, ex2mem_reg_wen_d;
  logic [4:0]  ex2mem_reg_waddr_q, ex2mem_reg_waddr_d;
  logic [31:0] ex2mem_alu_out_q, ex2mem_alu_out_d;
  logic        ex2mem_ill_instr_q, ex2mem_ill_instr_d;
  logic [31:0] rf_q [32];

  // ---------------------------------------------------------------- IF
  always_comb begin
    pc_d       = pc_q + 32'd4;
    if2id_pc_d = pc_q;
    if_valid_d = 1'b1;
  end

  assign bus.instr_ram_rd   = ~rst;
  assign bus.instr_ram_addr = pc_q[INSTR_RAM_AW+1:2];

  // if2id_pc is consumed by branch logic in the full core; these stages have none.
  logic unused_if2id_pc;
  assign unused_if2id_pc = ^if2id_pc_q;

  // ---------------------------------------------------------------- ID
  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        is_op, is_op_imm, legal;
  logic [31:0] rs1_rdata, rs2_rdata;

  assign instr  = bus.instr_ram_din;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  always_comb begin
    is_op     = (opcode == OPC_OP);
    is_op_imm = (opcode == OPC_OP_IMM);
    legal     = 1'b0;
    if (is_op) begin
      legal = (funct7 == F7_ZERO) ||
              ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
    end else if (is_op_imm) begin
      if (funct3 == F3_SLL)      legal = (funct7 == F7_ZERO);
      else if (funct3 == F3_SR)  legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
      else                       legal = 1'b1;
    end
  end

  // Register read with write-through: a WB write in this cycle is seen by the
  // read, covering the producer three words ahead.
  always_comb begin
    rs1_rdata = rf_q[rs1];
    if (bus.wb_reg_wen && (bus.wb_reg_waddr == rs1)) rs1_rdata = bus.wb_reg_wdata;
    if (rs1 == 5'd0) rs1_rdata = '0;
    rs2_rdata = rf_q[rs2];
    if (bus.wb_reg_wen && (bus.wb_reg_waddr == rs2)) rs2_rdata = bus.wb_reg_wdata;
    if (rs2 == 5'd0) rs2_rdata = '0;
  end

  always_comb begin
    id_ex_d       = '0;
    id_ex_d.valid = if_valid_q;
    if (if_valid_q) begin
      id_ex_d.reg_wen   = legal && (rd != 5'd0);
      id_ex_d.ill_instr = ~legal;
      id_ex_d.waddr     = rd;
    end
    id_ex_d.funct3   = funct3;
    // instr[30] is an immediate bit for ADDI etc., so it only selects SUB/SRA where it is funct7.
    id_ex_d.alt      = instr[30] && (is_op || (funct3 == F3_SR));
    id_ex_d.sel_imm  = is_op_imm;
    id_ex_d.imm      = instr[31:20];
    id_ex_d.rs1_data = rs1_rdata;
    id_ex_d.rs2_data = rs2_rdata;
    // The producer one word ahead sits in EX now and reaches MEM when we reach EX;
    // the one two words ahead sits in MEM now and reaches WB.
    id_ex_d.rs1_fwd_mem = (rs1 != 5'd0) && id_ex_q.reg_wen && (id_ex_q.waddr == rs1);
    id_ex_d.rs1_fwd_wb  = (rs1 != 5'd0) && ex2mem_reg_wen_q && (ex2mem_reg_waddr_q == rs1);
    id_ex_d.rs2_fwd_mem = (rs2 != 5'd0) && id_ex_q.reg_wen && (id_ex_q.waddr == rs2);
    id_ex_d.rs2_fwd_wb  = (rs2 != 5'd0) && ex2mem_reg_wen_q && (ex2mem_reg_waddr_q == rs2);
  end

  // ---------------------------------------------------------------- EX
  logic [31:0] op_a, op_b_reg, op_b, alu_res;
  logic [4:0]  shamt;

  always_comb begin
    if (id_ex_q.rs1_fwd_mem)     op_a = ex2mem_alu_out_q;
    else if (id_ex_q.rs1_fwd_wb) op_a = bus.wb_reg_wdata;
    else                         op_a = id_ex_q.rs1_data;

    if (id_ex_q.rs2_fwd_mem)     op_b_reg = ex2mem_alu_out_q;
    else if (id_ex_q.rs2_fwd_wb) op_b_reg = bus.wb_reg_wdata;
    else                         op_b_reg = id_ex_q.rs2_data;

    op_b  = id_ex_q.sel_imm ? {{20{id_ex_q.imm[11]}}, id_ex_q.imm} : op_b_reg;
    shamt = op_b[4:0];

    case (id_ex_q.funct3)
      F3_ADD:  alu_res = id_ex_q.alt ? (op_a - op_b) : (op_a + op_b);
      F3_SLL:  alu_res = op_a << shamt;
      F3_SLT:  alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
      F3_SLTU: alu_res = {31'd0, (op_a < op_b)};
      F3_XOR:  alu_res = op_a ^ op_b;
      F3_SR: begin
        if (id_ex_q.alt) alu_res = $unsigned($signed(op_a) >>> shamt);
        else             alu_res = op_a >> shamt;
      end
      F3_OR:   alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase

    ex2mem_alu_out_d   = id_ex_q.valid ? alu_res : '0;
    ex2mem_reg_wen_d   = id_ex_q.reg_wen;
    ex2mem_reg_waddr_d = id_ex_q.waddr;
    ex2mem_ill_instr_d = id_ex_q.ill_instr;
  end

  assign bus.ex2mem_reg_wen   = ex2mem_reg_wen_q;
  assign bus.ex2mem_reg_waddr = ex2mem_reg_waddr_q;
  assign bus.ex2mem_alu_out   = ex2mem_alu_out_q;
  assign bus.ex2mem_ill_instr = ex2mem_ill_instr_q;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q               <= '0;
      if2id_pc_q         <= '0;
      if_valid_q         <= 1'b0;
      id_ex_q            <= '0;
      ex2mem_reg_wen_q   <= 1'b0;
      ex2mem_reg_waddr_q <= '0;
      ex2mem_alu_out_q   <= '0;
      ex2mem_ill_instr_q <= 1'b0;
    end else begin
      pc_q               <= pc_d;
      if2id_pc_q         <= if2id_pc_d;
      if_valid_q         <= if_valid_d;
      id_ex_q            <= id_ex_d;
      ex2mem_reg_wen_q   <= ex2mem_reg_wen_d;
      ex2mem_reg_waddr_q <= ex2mem_reg_waddr_d;
      ex2mem_alu_out_q   <= ex2mem_alu_out_d;
      ex2mem_ill_instr_q <= ex2mem_ill_instr_d;
    end
  end

  // Register file contents survive reset; x0 is never written.
  always_ff @(posedge clk) begin
    if (bus.wb_reg_wen && (bus.wb_reg_waddr != 5'd0)) begin
      rf_q[bus.wb_reg_waddr] <= bus.wb_reg_wdata;
    end
  end

endmodule

// File: tb/tb_riscv_front_stages.sv
// tb/tb_riscv_front_stages.sv - scoreboard bench for riscv_front_stages
module tb_riscv_front_stages;
  localparam int          AW        = 16;
  localparam int          MEM_WORDS = 1024;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] alu;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst;
  bit   mon_en = 1'b1;
  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t exp_q[$];
  logic [31:0] imem [MEM_WORDS];
  logic [31:0] mrf  [32];

  riscv_front_stages_if #(.INSTR_RAM_AW(AW)) bus ();
  riscv_front_stages #(.INSTR_RAM_AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  // Architectural interpreter: executes one word in program order on mrf.
  function automatic exp_t model_exec(input logic [31:0] w);
    exp_t        e;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        legal;
    logic [31:0] a, b, r;
    int          sh;
    opc = w[6:0]; rd = w[11:7]; f3 = w[14:12]; f7 = w[31:25];
    if (opc == 7'h33)      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    else if (opc == 7'h13) legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                                   (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
    else                   legal = 1'b0;
    a  = mrf[w[19:15]];
    b  = (opc == 7'h33) ? mrf[w[24:20]] : {{20{w[31]}}, w[31:20]};
    sh = int'(b % 32);
    case (f3)
      3'd0: r = (opc == 7'h33 && f7 == 7'h20) ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        if (f7 == 7'h20) r = $unsigned($signed(a) >>> sh);
        else             r = a >> sh;
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    e.wen   = legal && (rd != 5'd0);
    e.ill   = ~legal;
    e.waddr = rd;
    e.alu   = r;
    if (e.wen) mrf[rd] = r;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    int          sel;
    sel = int'($urandom_range(0, 19));
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    if (sel < 8) begin
      return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                   f3, rd, rs1, rs2);
    end else if (sel < 16) begin
      if (f3 == 3'd1) imm[11:5] = 7'h00;
      if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return enc_i(f3, rd, rs1, imm);
    end else if (sel < 18) begin
      return enc_r(7'h01, f3, rd, rs1, rs2);
    end
    return $urandom;
  endfunction

  task automatic load_directed();
    for (int i = 0; i < MEM_WORDS; i++) imem[i] = NOP;
    imem[0]  = enc_i(3'd0, 5'd1, 5'd0, 12'd5);
    imem[1]  = enc_i(3'd0, 5'd2, 5'd1, 12'd3);
    imem[2]  = enc_r(7'h00, 3'd0, 5'd3, 5'd1, 5'd2);
    imem[3]  = enc_i(3'd0, 5'd1, 5'd0, 12'hFFF);
    imem[7]  = enc_i(3'd5, 5'd4, 5'd1, 12'h404);
    imem[8]  = enc_i(3'd5, 5'd5, 5'd1, 12'd28);
    imem[9]  = enc_r(7'h00, 3'd2, 5'd6, 5'd1, 5'd0);
    imem[10] = enc_r(7'h00, 3'd3, 5'd7, 5'd1, 5'd0);
    imem[11] = 32'h0000_006F;
    imem[12] = 32'h4000_0033;
    imem[13] = enc_i(3'd0, 5'd0, 5'd0, 12'd7);
    imem[14] = enc_i(3'd0, 5'd8, 5'd0, 12'd1);
    imem[15] = enc_i(3'd0, 5'd9, 5'd0, 12'd100);
    imem[18] = enc_i(3'd0, 5'd10, 5'd9, 12'd1);
    for (int i = 22; i < 31; i++) imem[i] = enc_i(3'd0, 5'(i - 11), 5'(i - 12), 12'(i));
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < MEM_WORDS; i++) imem[i] = NOP;
    for (int i = 0; i < 31; i++) imem[i] = enc_i(3'd0, 5'(i + 1), 5'd0, 12'($urandom));
    for (int i = 31; i < 31 + n; i++) imem[i] = rand_instr();
  endtask

  // One cycle per iteration: issue the expected result of word cyc, act as the
  // synchronous RAM and as the one-register MEM stage feeding WB.
  task automatic run_cycles(input int n);
    logic [AW-1:0] a_s;
    logic          wen_s;
    logic [4:0]    wa_s;
    logic [31:0]   wd_s;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp_q.push_back(model_exec((cyc < MEM_WORDS) ? imem[cyc] : NOP));
      a_s   = bus.instr_ram_addr;
      wen_s = bus.ex2mem_reg_wen;
      wa_s  = bus.ex2mem_reg_waddr;
      wd_s  = bus.ex2mem_alu_out;
      @(posedge clk);
      #1;
      bus.instr_ram_din = (int'(a_s) < MEM_WORDS) ? imem[a_s[9:0]] : NOP;
      bus.wb_reg_wen    = wen_s;
      bus.wb_reg_waddr  = wa_s;
      bus.wb_reg_wdata  = wd_s;
      cyc++;
    end
  endtask

  task automatic clear_wb();
    bus.wb_reg_wen   = 1'b0;
    bus.wb_reg_waddr = '0;
    bus.wb_reg_wdata = '0;
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst) begin
          check("rst_ram_rd", {31'd0, bus.instr_ram_rd}, 32'd0);
          check("rst_ram_addr", {16'd0, bus.instr_ram_addr}, 32'd0);
          check("rst_wen", {31'd0, bus.ex2mem_reg_wen}, 32'd0);
          check("rst_waddr", {27'd0, bus.ex2mem_reg_waddr}, 32'd0);
          check("rst_alu", bus.ex2mem_alu_out, 32'd0);
          check("rst_ill", {31'd0, bus.ex2mem_ill_instr}, 32'd0);
        end else begin
          check("ram_rd", {31'd0, bus.instr_ram_rd}, 32'd1);
          check("ram_addr", {16'd0, bus.instr_ram_addr}, 32'(cyc % (1 << AW)));
          if (cyc < 3) begin
            check("bubble_wen", {31'd0, bus.ex2mem_reg_wen}, 32'd0);
            check("bubble_waddr", {27'd0, bus.ex2mem_reg_waddr}, 32'd0);
            check("bubble_alu", bus.ex2mem_alu_out, 32'd0);
            check("bubble_ill", {31'd0, bus.ex2mem_ill_instr}, 32'd0);
          end else if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: got no expected entry at cycle %0d", cyc);
          end else begin
            e = exp_q.pop_front();
            check("ex2mem_reg_wen", {31'd0, bus.ex2mem_reg_wen}, {31'd0, e.wen});
            check("ex2mem_ill_instr", {31'd0, bus.ex2mem_ill_instr}, {31'd0, e.ill});
            if (!e.ill) begin
              check("ex2mem_reg_waddr", {27'd0, bus.ex2mem_reg_waddr}, {27'd0, e.waddr});
              check("ex2mem_alu_out", bus.ex2mem_alu_out, e.alu);
            end
          end
        end
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.instr_ram_din = '0;
    clear_wb();
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    load_directed();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    run_cycles(28);

    // Reset in the middle of operation with instructions in flight.
    #2;
    rst = 1'b1;
    clear_wb();
    #1;
    check("midrst_ram_rd", {31'd0, bus.instr_ram_rd}, 32'd0);
    check("midrst_ram_addr", {16'd0, bus.instr_ram_addr}, 32'd0);
    check("midrst_wen", {31'd0, bus.ex2mem_reg_wen}, 32'd0);
    check("midrst_alu", bus.ex2mem_alu_out, 32'd0);
    exp_q.delete();
    load_random(300);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    run_cycles(31 + 300 + 8);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
